// File: rtl/irq_controller_pkg.sv
// irq_controller_pkg: register map and FSM encodings shared by the interrupt controller
package irq_controller_pkg;
  localparam logic [1:0] IRQ_PENDING_ADDR = 2'd0;
  localparam logic [1:0] IRQ_MASK_ADDR    = 2'd1;
  localparam logic [1:0] IRQ_MODE_ADDR    = 2'd2;
  localparam logic [1:0] IRQ_ID_ADDR      = 2'd3;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SVC  = 2'd2
  } state_t;
endpackage

// File: rtl/irq_sync.sv
// irq_sync: per-line flop synchroniser with a previous-sample register for edge detection
module irq_sync #(
  parameter int N_IRQ       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [N_IRQ-1:0] i_irq,
  output logic [N_IRQ-1:0] s,
  output logic [N_IRQ-1:0] p
);
  logic [N_IRQ-1:0] chain [SYNC_STAGES];
  // shift raw lines through the chain; p holds last cycle's synchronised sample
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) chain[k] <= '0;
      p <= '0;
    end else begin
      chain[0] <= i_irq;
      for (int k = 1; k < SYNC_STAGES; k++) chain[k] <= chain[k-1];
      p <= chain[SYNC_STAGES-1];
    end
  end
  assign s = chain[SYNC_STAGES-1];
endmodule

// File: rtl/irq_controller.sv
// irq_controller: pending/mask/mode registers, lowest-index priority and request FSM feeding cop0
module irq_controller
  import irq_controller_pkg::*;
#(
  parameter int N_IRQ       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int ID_W        = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [N_IRQ-1:0] i_irq,
  input  logic             i_we,
  input  logic [1:0]       i_addr,
  input  logic [31:0]      i_wdata,
  output logic [31:0]      o_rdata,
  input  logic             i_exception_taken,
  input  logic             i_eret,
  output logic             o_external_interrupt,
  output logic [ID_W-1:0]  o_irq_id
);
  logic [N_IRQ-1:0] s, p, pending, mask, mode, pend_nxt, masked, w1c;
  logic [ID_W-1:0]  pri_id, active_id;
  logic             req, wr_mask, wr_mode, unused_wdata;
  state_t           state, state_nxt;

  irq_sync #(.N_IRQ(N_IRQ), .SYNC_STAGES(SYNC_STAGES)) u_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_irq   (i_irq),
    .s       (s),
    .p       (p)
  );

  assign unused_wdata = ^i_wdata[31:N_IRQ];
  assign wr_mask      = i_we && i_addr == IRQ_MASK_ADDR;
  assign wr_mode      = i_we && i_addr == IRQ_MODE_ADDR;
  assign w1c          = (i_we && i_addr == IRQ_PENDING_ADDR) ? i_wdata[N_IRQ-1:0] : '0;
  assign pend_nxt     = (mode & ((s & ~p) | (pending & ~w1c))) | (~mode & s);
  assign masked       = pending & mask;
  assign req          = |masked;

  // configuration and pending registers; a fresh edge beats a same-cycle W1C
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pending <= '0;
      mask    <= '0;
      mode    <= '0;
    end else begin
      pending <= pend_nxt;
      mask    <= wr_mask ? i_wdata[N_IRQ-1:0] : mask;
      mode    <= wr_mode ? i_wdata[N_IRQ-1:0] : mode;
    end
  end

  // lowest enabled pending index wins
  always_comb begin
    pri_id = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) if (masked[i]) pri_id = ID_W'(i);
  end

  // state register and id captured when cop0 accepts the request
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= ST_IDLE;
      active_id <= '0;
    end else begin
      state     <= state_nxt;
      active_id <= (state == ST_REQ && i_exception_taken) ? pri_id : active_id;
    end
  end

  // next state: acceptance beats eret in REQUEST; a dropped request is withdrawn
  always_comb begin
    state_nxt = state == ST_IDLE ? (req ? ST_REQ : ST_IDLE) :
                state == ST_REQ  ? (i_exception_taken ? ST_SVC : (req ? ST_REQ : ST_IDLE)) :
                state == ST_SVC  ? (i_eret ? ST_IDLE : ST_SVC) : ST_IDLE;
  end

  // request line and id view from the current state
  always_comb begin
    o_external_interrupt = state == ST_REQ;
    o_irq_id             = state == ST_REQ ? pri_id : (state == ST_SVC ? active_id : '0);
  end

  // combinational register read, PENDING as default
  always_comb begin
    o_rdata = i_addr == IRQ_MASK_ADDR ? 32'(mask) :
              i_addr == IRQ_MODE_ADDR ? 32'(mode) :
              i_addr == IRQ_ID_ADDR   ? ({state == ST_SVC, 31'd0} | 32'(active_id)) :
              32'(pending);
  end
endmodule
